// File: rtl/axi_burst_fetch_if.sv
// axi_burst_fetch_if: AXI4 read-address / read-data channel bundle used by the
// burst fetch stage. The master modport is the fetch side; slave is memory side.
interface axi_burst_fetch_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned USER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]   M_AXI_ARID;
  logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic [7:0]            M_AXI_ARLEN;
  logic [2:0]            M_AXI_ARSIZE;
  logic [1:0]            M_AXI_ARBURST;
  logic                  M_AXI_ARLOCK;
  logic [3:0]            M_AXI_ARCACHE;
  logic [2:0]            M_AXI_ARPROT;
  logic [3:0]            M_AXI_ARQOS;
  logic [USER_WIDTH-1:0] M_AXI_ARUSER;
  logic                  M_AXI_ARVALID;
  logic                  M_AXI_ARREADY;

  logic [ID_WIDTH-1:0]   M_AXI_RID;
  logic [DATA_WIDTH-1:0] M_AXI_RDATA;
  logic [1:0]            M_AXI_RRESP;
  logic                  M_AXI_RLAST;
  logic [USER_WIDTH-1:0] M_AXI_RUSER;
  logic                  M_AXI_RVALID;
  logic                  M_AXI_RREADY;

  modport master (
    output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
           M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARUSER,
           M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
           M_AXI_RUSER, M_AXI_RVALID
  );

  modport slave (
    input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
           M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARUSER,
           M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
           M_AXI_RUSER, M_AXI_RVALID
  );
endinterface

// File: rtl/axi_burst_fetch.sv
// axi_burst_fetch: AXI4 INCR-burst read master feeding the lexer fetch FIFO.
// Bursts are clipped at 4 KiB boundaries, one burst outstanding at a time, and
// new bursts are held off by STOP (return to idle) or THROTTLE (wait).
// Optional feature macro: AXI_BURST_FETCH_ERR_HALT_EN -- on an error response the
// offending and remaining beats of the burst are dropped and the block goes idle.
module axi_burst_fetch #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH      = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH      = 32,
  parameter int unsigned C_M_AXI_THREAD_ID_WIDTH = 1,
  parameter int unsigned BURST_LEN               = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          START,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] START_ADDR,
  input  logic                          STOP,
  input  logic                          THROTTLE,
  output logic                          BUSY,
  output logic                          ERR,
  output logic                          O_VALID,
  output logic [C_M_AXI_DATA_WIDTH-1:0] O_DATA,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] O_ADDR,
  axi_burst_fetch_if.master             m_axi
);
  localparam int unsigned AW     = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW     = C_M_AXI_DATA_WIDTH;
  localparam int unsigned LEN_W  = 9;
  localparam int unsigned ROOM_W = 11;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_NEXT} state_t;

  state_t           r_state;
  logic [AW-1:0]    r_addr;
  logic [AW-1:0]    r_beat_addr;
  logic [LEN_W-1:0] r_beats;
  logic [LEN_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_err;
  logic             r_arvalid;
  logic [AW-1:0]    r_araddr;
  logic [7:0]       r_arlen;
  logic             r_rready;
  logic             r_ovalid;
  logic [DW-1:0]    r_odata;
  logic [AW-1:0]    r_oaddr;
`ifdef AXI_BURST_FETCH_ERR_HALT_EN
  logic             r_drain;
`endif

  logic [ROOM_W-1:0] w_room;
  logic [LEN_W-1:0]  w_beats;
  logic              w_rhs;
  logic              w_rerr;
  logic              w_at_count;
  logic              w_fwd;
  logic              w_halt;
  logic              w_unused;

  // Words left before the next 4 KiB boundary, and the resulting burst length
  assign w_room     = ROOM_W'(1024) - ROOM_W'(r_addr[11:2]);
  assign w_beats    = (w_room > ROOM_W'(BURST_LEN)) ? LEN_W'(BURST_LEN) : LEN_W'(w_room);
  assign w_rhs      = m_axi.M_AXI_RVALID && r_rready;
  assign w_rerr     = (m_axi.M_AXI_RRESP != 2'b00);
  assign w_at_count = (r_cnt == (r_beats - LEN_W'(1)));

  // Forwarding/halting policy for error responses
`ifdef AXI_BURST_FETCH_ERR_HALT_EN
  assign w_fwd  = !r_drain && !w_rerr;
  assign w_halt = r_drain || w_rerr;
`else
  assign w_fwd  = 1'b1;
  assign w_halt = 1'b0;
`endif

  // Inputs with no role in this block (RID/RUSER ignored, address is word aligned)
  assign w_unused = ^{m_axi.M_AXI_RID, m_axi.M_AXI_RUSER, START_ADDR[1:0]};

  // Burst sequencer: latches start, sizes bursts, tracks beats, forwards words
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_beat_addr <= '0;
      r_beats     <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_arvalid   <= 1'b0;
      r_araddr    <= '0;
      r_arlen     <= '0;
      r_rready    <= 1'b0;
      r_ovalid    <= 1'b0;
      r_odata     <= '0;
      r_oaddr     <= '0;
`ifdef AXI_BURST_FETCH_ERR_HALT_EN
      r_drain     <= 1'b0;
`endif
    end else begin
      r_ovalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_addr  <= {START_ADDR[AW-1:2], 2'b00};
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (STOP) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (!THROTTLE) begin
            r_beats   <= w_beats;
            r_araddr  <= r_addr;
            r_arlen   <= 8'(w_beats - LEN_W'(1));
            r_arvalid <= 1'b1;
            r_state   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (m_axi.M_AXI_ARREADY) begin
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b1;
            r_cnt       <= '0;
            r_beat_addr <= r_addr;
`ifdef AXI_BURST_FETCH_ERR_HALT_EN
            r_drain     <= 1'b0;
`endif
            r_state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_rhs) begin
            r_cnt       <= r_cnt + LEN_W'(1);
            r_beat_addr <= r_beat_addr + AW'(4);
            if (w_fwd) begin
              r_ovalid <= 1'b1;
              r_odata  <= m_axi.M_AXI_RDATA;
              r_oaddr  <= r_beat_addr;
            end
            if (w_rerr) begin
              r_err <= 1'b1;
            end
`ifdef AXI_BURST_FETCH_ERR_HALT_EN
            if (w_rerr) begin
              r_drain <= 1'b1;
            end
`endif
            if (m_axi.M_AXI_RLAST) begin
              if (!w_at_count) begin
                r_err <= 1'b1;
              end
              r_rready <= 1'b0;
              r_addr   <= r_addr + AW'({r_beats, 2'b00});
              if (w_halt) begin
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_state <= S_NEXT;
              end
            end else if (w_at_count) begin
              r_err <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign BUSY    = r_busy;
  assign ERR     = r_err;
  assign O_VALID = r_ovalid;
  assign O_DATA  = r_odata;
  assign O_ADDR  = r_oaddr;

  assign m_axi.M_AXI_ARID    = C_M_AXI_THREAD_ID_WIDTH'(0);
  assign m_axi.M_AXI_ARADDR  = r_araddr;
  assign m_axi.M_AXI_ARLEN   = r_arlen;
  assign m_axi.M_AXI_ARSIZE  = 3'b010;
  assign m_axi.M_AXI_ARBURST = 2'b01;
  assign m_axi.M_AXI_ARLOCK  = 1'b0;
  assign m_axi.M_AXI_ARCACHE = 4'b0011;
  assign m_axi.M_AXI_ARPROT  = 3'b000;
  assign m_axi.M_AXI_ARQOS   = 4'b0000;
  assign m_axi.M_AXI_ARUSER  = '0;
  assign m_axi.M_AXI_ARVALID = r_arvalid;
  assign m_axi.M_AXI_RREADY  = r_rready;
endmodule

// File: doc/axi_burst_fetch.md
# axi_burst_fetch

AXI4 read-master fetch stage that streams consecutive 32-bit words from memory into the fetch FIFO ahead of the lexer. It replaces single-beat fetching with INCR bursts, splits bursts at 4 KiB boundaries, and stops issuing new bursts while the downstream FIFO lacks room for a whole burst. Sits between the AXI master port of the core and the 32-in/8-out fetch FIFO.

## Interface
- C_M_AXI_ADDR_WIDTH, 32, address width (byte address)
- C_M_AXI_DATA_WIDTH, 32, data width; only 32 supported
- C_M_AXI_THREAD_ID_WIDTH, 1, ARID/RID width
- BURST_LEN, 16, maximum beats per burst (1..256)
- Clock and reset: one clock, ACLK; reset ARESETN is asynchronous, active-low.
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- START  in  1  one-cycle pulse; begin fetching at START_ADDR (ignored while BUSY)
- START_ADDR  in  ADDR_WIDTH  first byte address; bits [1:0] forced to 0
- STOP  in  1  level; no new burst is issued while high
- THROTTLE  in  1  high = downstream FIFO cannot accept BURST_LEN more words
- BUSY  out  1  high from START accept until the last R beat of the final burst
- ERR  out  1  sticky; set on any RRESP != OKAY, cleared only by START or reset
- O_VALID  out  1  one-cycle strobe per fetched word (FIFO wr_en)
- O_DATA  out  32  fetched word
- O_ADDR  out  ADDR_WIDTH  byte address of O_DATA
- M_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARLOCK/ARCACHE/ARPROT/ARQOS/ARUSER/ARVALID  out; M_AXI_ARREADY in
- M_AXI_RID/RDATA/RRESP/RLAST/RUSER/RVALID  in; M_AXI_RREADY out

## Operation
- Constants: ARID 0, ARSIZE 3'b010, ARBURST 2'b01 (INCR), ARLOCK 0, ARCACHE 4'b0011, ARPROT 0, ARQOS 0, ARUSER 0.
- States: IDLE, ADDR, DATA, NEXT.
- IDLE: BUSY=0. START -> latch addr, clear ERR, go NEXT.
- NEXT: if STOP -> IDLE. Else if THROTTLE -> stay. Else compute beats and go ADDR.
- Beat count: beats = min(BURST_LEN, (4096 - addr[11:0]) >> 2); ARLEN = beats-1. Bursts never cross a 4 KiB boundary.
- ADDR: ARVALID=1, ARADDR=addr, ARLEN held stable until ARREADY; on handshake -> DATA.
- DATA: RREADY=1 continuously; each RVALID beat produces one O_VALID. On beat with RLAST -> addr += beats*4 (wraps modulo 2^ADDR_WIDTH), go NEXT.
- Only one outstanding burst at any time; RID ignored.
- RLAST arriving before the counted beat count or a missing RLAST at the counted beat: the burst ends on RLAST; ERR is set if the beat count mismatches.
- STOP/THROTTLE never abort a burst in progress; they take effect at NEXT.

## Timing
- Reset values: ARVALID 0, RREADY 0, BUSY 0, ERR 0, O_VALID 0, O_DATA 0, O_ADDR 0, ARADDR 0, ARLEN 0.
- START at cycle 0 -> NEXT at 1 -> ARVALID high at cycle 2 (no THROTTLE/STOP).
- O_VALID/O_DATA/O_ADDR registered: asserted the cycle after each RVALID&&RREADY handshake.
- After the RLAST handshake, the next ARVALID rises 2 cycles later (NEXT then ADDR) when unthrottled.
- BUSY falls the cycle after leaving for IDLE; the final O_VALID may coincide with the BUSY fall.
- ARESETN low mid-burst: all outputs go to reset values immediately; the interconnect must be reset together.
- START while BUSY: ignored, no effect on ERR.

## Configuration
- AXI_BURST_FETCH_ERR_HALT_EN defined: a beat with RRESP != OKAY sets ERR, its O_VALID is suppressed, remaining beats of that burst are drained without O_VALID, then the block enters IDLE.
- Not defined: ERR is set but every beat is forwarded and fetching continues normally.

## Test plan
- START_ADDR 0x1000, BURST_LEN 16, STOP after first burst -> ARADDR 0x1000, ARLEN 15, 16 O_VALID with O_ADDR 0x1000..0x103C, then IDLE.
- START_ADDR 0x0FF8 -> first burst ARLEN 1 (2 beats), second burst ARADDR 0x1000, ARLEN 15.
- THROTTLE high for 20 cycles after first RLAST -> ARVALID stays low for those 20 cycles, then the burst issues at 0x1040.
- ARREADY delayed 5 cycles, RVALID gapped every other cycle -> ARADDR/ARLEN stable while waiting, O_DATA sequence exact, no duplicate or lost words.
- RRESP=SLVERR on beat 3 -> ERR=1; with AXI_BURST_FETCH_ERR_HALT_EN, 3 words are output, then IDLE; without it, 16 words are output and fetching continues.
- ARESETN asserted mid-DATA -> all outputs 0 the same cycle; after release with START at 0x2000, normal fetch resumes.
